// File: rtl/ram_scanner.sv
// Reads every RAM word in address order and presents each one on a valid/ready output port.
// Latency: first word is valid 3 cycles after start is sampled; one word per 3 cycles at best.
// Backpressure: holds the current word stable until accepted; no new read issues until then.
// Optional running 8-bit checksum over each pass when RAM_SCANNER_CHECKSUM_EN is defined.
module ram_scanner #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              continuous,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done
`ifdef RAM_SCANNER_CHECKSUM_EN
    ,
    output logic [7:0]        checksum
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] CAPT = 2'd2;
    localparam logic [1:0] HOLD = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    logic [1:0] state;
    logic       xfer;
    logic       at_last;

    // out_valid is only ever set in HOLD, so xfer implies HOLD.
    assign xfer     = out_valid & out_ready;
    assign at_last  = (mem_address == LAST_ADDR);
    assign mem_wren = 1'b0;
    assign busy     = (state != IDLE);

    // Scan sequencer: issue read, capture the returned word, hold it until accepted.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            mem_address <= '0;
            out_data    <= '0;
            out_addr    <= '0;
            out_valid   <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mem_address <= '0;
                        state       <= REQ;
                    end
                end
                // Address has been on the RAM port for one edge; data arrives next cycle.
                REQ: begin
                    state <= CAPT;
                end
                CAPT: begin
                    out_data  <= mem_q;
                    out_addr  <= mem_address;
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (xfer) begin
                        out_valid <= 1'b0;
                        if (at_last) begin
                            // continuous only matters here, at the end of a pass.
                            done <= 1'b1;
                            if (continuous) begin
                                mem_address <= '0;
                                state       <= REQ;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            mem_address <= mem_address + 1'b1;
                            state       <= REQ;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef RAM_SCANNER_CHECKSUM_EN
    logic [7:0] word_ext;

    assign word_ext = 8'(out_data);

    // Running sum of accepted words; the address-0 word restarts the sum for a new pass.
    always_ff @(posedge clock) begin
        if (reset) begin
            checksum <= '0;
        end else if (xfer) begin
            if (out_addr == '0) begin
                checksum <= word_ext;
            end else begin
                checksum <= checksum + word_ext;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ram_scanner.sv
// Directed bench for ram_scanner with a behavioural 32x4 RAM model.
// Inputs driven and outputs sampled on the falling clock edge.
// Checksum scenario is compiled only when RAM_SCANNER_CHECKSUM_EN is defined.
module tb_ram_scanner;

    logic       clock;
    logic       reset;
    logic       start;
    logic       continuous;
    logic [4:0] mem_address;
    logic       mem_wren;
    logic [3:0] mem_q;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic [4:0] out_addr;
    logic       busy;
    logic       done;
`ifdef RAM_SCANNER_CHECKSUM_EN
    logic [7:0] checksum;
`endif

    logic [3:0] mem [32];

    int total = 0;
    int bad = 0;
    int done_cnt = 0;

    ram_scanner #(.ADDR_W(5), .DATA_W(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .continuous  (continuous),
        .mem_address (mem_address),
        .mem_wren    (mem_wren),
        .mem_q       (mem_q),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_addr    (out_addr),
        .busy        (busy),
        .done        (done)
`ifdef RAM_SCANNER_CHECKSUM_EN
        ,
        .checksum    (checksum)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Registered-read RAM: data for an address is available one cycle later.
    always @(posedge clock) begin
        mem_q <= mem[mem_address];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        if (done === 1'b1) done_cnt++;
        check("mem_wren", {31'd0, mem_wren}, 32'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Wait for a word, check it, optionally stall for `hold` cycles, then accept it.
    task automatic take_word(input int a, input int hold);
        logic [3:0] exp_d;
        int k;
        exp_d = mem[a];
        out_ready = 1'b0;
        k = 0;
        while (out_valid !== 1'b1 && k < 10) begin
            tick();
            k++;
        end
        check("word_valid", {31'd0, out_valid}, 32'd1);
        check("word_addr", {27'd0, out_addr}, a);
        check("word_data", {28'd0, out_data}, {28'd0, exp_d});
        for (int h = 0; h < hold; h++) begin
            tick();
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_addr", {27'd0, out_addr}, a);
            check("hold_data", {28'd0, out_data}, {28'd0, exp_d});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic take_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) take_word(i, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_maddr"}, {27'd0, mem_address}, 32'd0);
        check({tag, "_odata"}, {28'd0, out_data}, 32'd0);
        check({tag, "_oaddr"}, {27'd0, out_addr}, 32'd0);
`ifdef RAM_SCANNER_CHECKSUM_EN
        check({tag, "_csum"}, {24'd0, checksum}, 32'd0);
`endif
    endtask

    initial begin
        int n;
        int gap;
        int dc;
        int k;

        for (int i = 0; i < 32; i++) mem[i] = 4'(i) ^ 4'hA;
        reset      = 1'b1;
        start      = 1'b0;
        continuous = 1'b0;
        out_ready  = 1'b0;
        tick();
        tick();
        check_reset_outputs("rst");
        reset = 1'b0;
        tick();
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_valid", {31'd0, out_valid}, 32'd0);

        // Full pass at full throughput, exact first-word latency.
        out_ready = 1'b1;
        pulse_start();
        check("lat_req_busy", {31'd0, busy}, 32'd1);
        check("lat_req_valid", {31'd0, out_valid}, 32'd0);
        tick();
        check("lat_capt_valid", {31'd0, out_valid}, 32'd0);
        tick();
        check("lat_hold_valid", {31'd0, out_valid}, 32'd1);
        n = 0;
        gap = 0;
        for (int c = 0; c < 200 && n < 32; c++) begin
            if (out_valid === 1'b1) begin
                check("p1_addr", {27'd0, out_addr}, n);
                check("p1_data", {28'd0, out_data}, {28'd0, mem[n]});
                if (n > 0) check("p1_gap", gap, 2);
                n++;
                gap = 0;
            end else begin
                gap++;
            end
            tick();
        end
        check("p1_count", n, 32);
        check("p1_done", {31'd0, done}, 32'd1);
        check("p1_busy_after", {31'd0, busy}, 32'd0);
        check("p1_done_cnt", done_cnt, 1);
        out_ready = 1'b0;
        tick();
        check("p1_done_pulse", {31'd0, done}, 32'd0);

        // Backpressure at address 7.
        pulse_start();
        take_range(0, 6);
        take_word(7, 5);
        check("bp_word7", {28'd0, mem[7]}, 32'hD);
        take_range(8, 31);
        check("bp_done", {31'd0, done}, 32'd1);
        check("bp_busy", {31'd0, busy}, 32'd0);
        check("bp_done_cnt", done_cnt, 2);

        // Continuous mode: wrap, done per pass, stop after continuous drops.
        continuous = 1'b1;
        pulse_start();
        take_range(0, 31);
        check("c1_done", {31'd0, done}, 32'd1);
        check("c1_busy", {31'd0, busy}, 32'd1);
        take_range(0, 9);
        continuous = 1'b0;
        take_range(10, 31);
        check("c2_done", {31'd0, done}, 32'd1);
        check("c2_busy", {31'd0, busy}, 32'd0);
        check("c2_done_cnt", done_cnt, 4);
        tick();
        tick();
        tick();
        check("c2_idle_busy", {31'd0, busy}, 32'd0);
        check("c2_idle_valid", {31'd0, out_valid}, 32'd0);

        // Reset in HOLD at address 12, with start and a transfer competing.
        pulse_start();
        take_range(0, 11);
        k = 0;
        while (out_valid !== 1'b1 && k < 10) begin
            tick();
            k++;
        end
        check("r12_addr", {27'd0, out_addr}, 32'd12);
        dc = done_cnt;
        reset     = 1'b1;
        start     = 1'b1;
        out_ready = 1'b1;
        tick();
        check_reset_outputs("midrst");
        reset     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        tick();
        check("midrst_after_busy", {31'd0, busy}, 32'd0);
        check("midrst_no_done", done_cnt, dc);

        // start held high while busy must not restart the pass.
        pulse_start();
        start = 1'b1;
        take_range(0, 2);
        start = 1'b0;
        take_range(3, 31);
        check("nr_done", {31'd0, done}, 32'd1);
        check("nr_done_cnt", done_cnt, dc + 1);

`ifdef RAM_SCANNER_CHECKSUM_EN
        for (int i = 0; i < 32; i++) mem[i] = 4'hF;
        pulse_start();
        take_range(0, 31);
        check("cs_done", {31'd0, done}, 32'd1);
        check("cs_full", {24'd0, checksum}, 32'hE0);
        tick();
        check("cs_hold", {24'd0, checksum}, 32'hE0);
        pulse_start();
        take_word(0, 0);
        check("cs_restart", {24'd0, checksum}, 32'h0F);
        take_word(1, 0);
        check("cs_second", {24'd0, checksum}, 32'h1E);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_scanner.md
RAM_SCANNER -- requirements
Module: ram_scanner

Interface
REQ-001 Parameters: ADDR_W, default 5, RAM address width; DATA_W, default 4, RAM word width. Last address = 2^ADDR_W-1.
REQ-002 Single clock domain. Reset is synchronous and active-high.
REQ-003 clock  in  1  rising-edge clock, shared with the ram32x4 instance.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  level sampled each edge; high in IDLE begins a pass at address 0.
REQ-006 continuous  in  1  high: wrap to address 0 after the last address; low: stop.
REQ-007 mem_address  out  ADDR_W  RAM read address.
REQ-008 mem_wren  out  1  RAM write enable; constant 0.
REQ-009 mem_q  in  DATA_W  RAM read data, valid the cycle after mem_address is presented.
REQ-010 out_valid  out  1  out_data/out_addr hold a word.
REQ-011 out_ready  in  1  consumer accepts; transfer = out_valid & out_ready at an edge.
REQ-012 out_data  out  DATA_W  word read.
REQ-013 out_addr  out  ADDR_W  address of out_data.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 done  out  1  one-cycle pulse after the transfer of the last address.

Function
REQ-016 FSM has states IDLE, REQ, CAPT and HOLD.
REQ-017 IDLE->REQ when start=1; mem_address=0.
REQ-018 REQ->CAPT unconditionally; mem_address is held.
REQ-019 CAPT->HOLD; out_data<=mem_q, out_addr<=mem_address, out_valid<=1.
REQ-020 HOLD persists until a transfer; out_data/out_addr are stable while out_valid=1 and out_ready=0.
REQ-021 On transfer at a non-last address: out_valid<=0, mem_address+1, ->REQ.
REQ-022 On transfer at the last address: out_valid<=0 and done<=1 next cycle. continuous=1: mem_address<=0, ->REQ. continuous=0: ->IDLE.
REQ-023 continuous is evaluated only at the last-address transfer; changes mid-pass have no other effect.
REQ-024 Latency: start sampled at edge k -> REQ in cycle k+1 -> CAPT in cycle k+2 -> out_valid=1 from cycle k+3.
REQ-025 Throughput: one word per 3 cycles with out_ready held 1; out_valid is low for exactly 2 cycles between words.
REQ-026 start is ignored while busy=1.
REQ-027 out_ready asserted while out_valid=0 has no effect.
REQ-028 Address arithmetic is modulo 2^ADDR_W.
REQ-029 done pulses at the end of every pass, including continuous passes.

Reset
REQ-030 reset=1 at an edge: state=IDLE; mem_address, out_data, out_addr=0; out_valid, busy, done=0; checksum=0.
REQ-031 reset takes priority over start and over any transfer in the same cycle.
REQ-032 Reset mid-pass abandons the pass without a done pulse.

Configuration
REQ-033 Macro RAM_SCANNER_CHECKSUM_EN, when defined, adds port checksum  out  8  running sum.
REQ-034 With the macro, on each transfer: address 0 -> checksum<=zero-extended word; otherwise checksum<=checksum+word mod 256.
REQ-035 With the macro, checksum holds the full-pass sum in the done cycle and holds its value until the next address-0 transfer or reset.
REQ-036 Without the macro, no checksum port and no checksum logic exist; all other behaviour is identical.

Verification
REQ-037 Preload mem[i]=i[3:0]^4'hA, continuous=0, out_ready=1, pulse start -> out_valid at cycle start+3; 32 transfers with out_addr 0..31 and out_data=mem[out_addr]; one done pulse; busy=0 after.
REQ-038 Hold out_ready=0 for 5 cycles while out_addr=7 -> out_data=4'hD and out_addr=7 stable; next transfer is address 8; no skip or duplicate.
REQ-039 continuous=1 -> address 31 is followed by address 0 and done pulses each pass; drop continuous at address 10 of pass 2 -> stops after address 31 and returns to IDLE.
REQ-040 Assert reset with start=1 during HOLD at address 12 -> next cycle all outputs 0, IDLE, no done; start pulse while busy -> no restart.
REQ-041 RAM_SCANNER_CHECKSUM_EN defined, all words 4'hF -> checksum=8'hE0 in the done cycle; second pass restarts at 8'h0F after address 0.
REQ-042 All scenarios -> mem_wren=0 in every cycle.
